// File: rtl/bc_pkg.sv
// Shared encodings for the output readback monitor: FSM states, fbStatus codes and the lock threshold.
package bc_pkg;

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_TRACK    = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_ERROR    = 3'd3,
    ST_LOCK     = 3'd4
  } mon_state_t;

  localparam logic [1:0] FB_OK     = 2'b00;
  localparam logic [1:0] FB_SETTLE = 2'b01;
  localparam logic [1:0] FB_LOCK   = 2'b10;
  localparam logic [1:0] FB_OFF    = 2'b11;

  // Settle failures tolerated before the third one locks the monitor.
  localparam logic [1:0] ERR_LOCK_LIMIT = 2'd2;

  function automatic logic [1:0] status_of(input mon_state_t st);
    logic [1:0] code;
    case (st)
      ST_DISABLED:         code = FB_OFF;
      ST_TRACK:            code = FB_OK;
      ST_SETTLE, ST_ERROR: code = FB_SETTLE;
      ST_LOCK:             code = FB_LOCK;
      default:             code = FB_LOCK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/fb_sync_filter.sv
// One readback channel: 2-flop synchroniser, optional glitch filter (FB_GLITCH_FILTER_EN), and a
// command delay line matched to the readback latency.
module fb_sync_filter
  import bc_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd,
  input  logic fb,
  output logic fb_clean,
  output logic cmd_dly
);

  if (FILT_LEN < 2) begin : g_bad_filt_len
    $error("fb_sync_filter: FILT_LEN must be at least 2");
  end

`ifdef FB_GLITCH_FILTER_EN
  localparam int DLY = 2 + FILT_LEN;
`else
  localparam int DLY = 2;
`endif

  logic           cmd_r;
  logic [DLY-1:0] cmd_pipe_r;
  logic           sync1_r;
  logic           sync2_r;

  // Command register plus delay line, and the readback synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_r      <= 1'b0;
      cmd_pipe_r <= '0;
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
    end else begin
      cmd_r      <= cmd;
      cmd_pipe_r <= {cmd_pipe_r[DLY-2:0], cmd_r};
      sync1_r    <= fb;
      sync2_r    <= sync1_r;
    end
  end

  assign cmd_dly = cmd_pipe_r[DLY-1];

`ifdef FB_GLITCH_FILTER_EN
  logic [FILT_LEN-2:0] hist_r;
  logic                clean_r;
  logic                all_one_s;
  logic                all_zero_s;

  // The current sample plus FILT_LEN-1 history bits form the FILT_LEN-sample window.
  assign all_one_s  = sync2_r & (&hist_r);
  assign all_zero_s = ~sync2_r & ~(|hist_r);

  // Sample history and filtered value; the output only moves on a unanimous window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r  <= '0;
      clean_r <= 1'b0;
    end else begin
      hist_r <= (hist_r << 1) | (FILT_LEN-1)'(sync2_r);
      if (all_one_s) begin
        clean_r <= 1'b1;
      end else if (all_zero_s) begin
        clean_r <= 1'b0;
      end else begin
        clean_r <= clean_r;
      end
    end
  end

  assign fb_clean = clean_r;
`else
  assign fb_clean = sync2_r;
`endif

endmodule

// File: rtl/output_readback_monitor.sv
// Checks relay/switch readback against the latency-matched commands and locks after the third
// settle failure. Optional glitch filter on the readback: define FB_GLITCH_FILTER_EN.
module output_readback_monitor
  import bc_pkg::*;
#(
  parameter int         SETTLE_MAX = 250000,
  parameter int         CNT_W      = 18,
  parameter logic [1:0] FB_INV     = 2'b00,
  parameter int         FILT_LEN   = 4
) (
  input  logic       clk1,
  input  logic       rst,
  input  logic       monEn,
  input  logic       relayCmd,
  input  logic       switchCmd,
  input  logic       relayFb,
  input  logic       switchFb,
  input  logic       clrErr,
  output logic [1:0] fbStatus,
  output logic       fbFault,
  output logic [1:0] errCount
);

  if ((SETTLE_MAX < 2) || ((64'd1 << CNT_W) <= 64'(SETTLE_MAX))) begin : g_bad_settle
    $error("output_readback_monitor: need SETTLE_MAX >= 2 and 2**CNT_W > SETTLE_MAX");
  end

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_MAX - 1);

  mon_state_t       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic [1:0]       err_r, err_s;
  logic [1:0]       status_r;
  logic             fault_r;
  logic [1:0]       fb_clean_s, cmd_dly_s, cmd_prev_r;
  logic             mismatch_s, cmd_toggle_s;

  fb_sync_filter #(.FILT_LEN(FILT_LEN)) u_relay (
    .clk(clk1), .rst_n(rst), .cmd(relayCmd), .fb(relayFb),
    .fb_clean(fb_clean_s[0]), .cmd_dly(cmd_dly_s[0])
  );

  fb_sync_filter #(.FILT_LEN(FILT_LEN)) u_switch (
    .clk(clk1), .rst_n(rst), .cmd(switchCmd), .fb(switchFb),
    .fb_clean(fb_clean_s[1]), .cmd_dly(cmd_dly_s[1])
  );

  assign mismatch_s   = |(fb_clean_s ^ (cmd_dly_s ^ FB_INV));
  assign cmd_toggle_s = |(cmd_dly_s ^ cmd_prev_r);
  assign cnt_inc_s    = cnt_r + CNT_W'(1);

  // Next state, settle counter and error counter.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    err_s   = err_r;
    case (state_r)
      ST_DISABLED: begin
        cnt_s = '0;
        if (clrErr) err_s = 2'd0;
        else        err_s = err_r;
        if (monEn) state_s = ST_TRACK;
        else       state_s = ST_DISABLED;
      end
      ST_TRACK: begin
        cnt_s = '0;
        if (clrErr) err_s = 2'd0;
        else        err_s = err_r;
        if (!monEn)         state_s = ST_DISABLED;
        else if (mismatch_s) state_s = ST_SETTLE;
        else                state_s = ST_TRACK;
      end
      ST_SETTLE: begin
        // The cycle that sees the mismatch in TRACK counts, so exactly SETTLE_MAX
        // mismatching cycles reach the limit.
        if (!monEn) begin
          state_s = ST_DISABLED;
          cnt_s   = '0;
        end else if (!mismatch_s) begin
          state_s = ST_TRACK;
          cnt_s   = '0;
        end else if (cmd_toggle_s) begin
          cnt_s = '0;
        end else if (cnt_inc_s == SETTLE_LAST) begin
          state_s = ST_ERROR;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      ST_ERROR: begin
        cnt_s = '0;
        if (!monEn) begin
          state_s = ST_DISABLED;
        end else if (err_r < ERR_LOCK_LIMIT) begin
          err_s   = err_r + 2'd1;
          state_s = ST_TRACK;
        end else begin
          err_s   = 2'd3;
          state_s = ST_LOCK;
        end
      end
      ST_LOCK: begin
        state_s = ST_LOCK;
        cnt_s   = '0;
      end
      default: begin
        state_s = ST_LOCK;
        cnt_s   = '0;
        err_s   = 2'd3;
      end
    endcase
  end

  // State, counters and registered outputs; status is decoded from the next state.
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_DISABLED;
      cnt_r      <= '0;
      err_r      <= 2'd0;
      cmd_prev_r <= 2'b00;
      status_r   <= FB_OFF;
      fault_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      err_r      <= err_s;
      cmd_prev_r <= cmd_dly_s;
      status_r   <= status_of(state_s);
      fault_r    <= fault_r | (state_s == ST_LOCK);
    end
  end

  assign fbStatus = status_r;
  assign fbFault  = fault_r;
  assign errCount = err_r;

endmodule

// File: tb/tb_output_readback_monitor.sv
// Directed self-checking bench for output_readback_monitor (short SETTLE_MAX, inverted switch feedback).
module tb_output_readback_monitor;

  localparam int SM = 12;
`ifdef FB_GLITCH_FILTER_EN
  localparam int XL = 4;
`else
  localparam int XL = 0;
`endif

  logic       clk1 = 1'b0;
  logic       rst = 1'b1;
  logic       monEn = 1'b0;
  logic       relayCmd = 1'b0;
  logic       switchCmd = 1'b0;
  logic       relayFb = 1'b0;
  logic       switchFb = 1'b1;
  logic       clrErr = 1'b0;
  logic [1:0] fbStatus;
  logic       fbFault;
  logic [1:0] errCount;

  int checks = 0;
  int errors = 0;

  output_readback_monitor #(
    .SETTLE_MAX(SM), .CNT_W(4), .FB_INV(2'b10), .FILT_LEN(4)
  ) dut (
    .clk1(clk1), .rst(rst), .monEn(monEn), .relayCmd(relayCmd), .switchCmd(switchCmd),
    .relayFb(relayFb), .switchFb(switchFb), .clrErr(clrErr),
    .fbStatus(fbStatus), .fbFault(fbFault), .errCount(errCount)
  );

  always #5 clk1 = ~clk1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Switch feedback is inverted: correct is ~switchCmd, stuck-wrong is switchCmd.
  task automatic stuck_switch(input int n);
    switchFb = switchCmd;
    tick(n);
    switchFb = ~switchCmd;
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("reset_status", fbStatus, 2'b11);
    chk("reset_fault", {1'b0, fbFault}, 2'b00);
    chk("reset_err", errCount, 2'd0);
    tick(2);
    rst = 1'b1;
    tick(6 + XL);
    chk("disabled_status", fbStatus, 2'b11);

    monEn = 1'b1;
    tick(1);
    chk("enable_status", fbStatus, 2'b00);

    // Readback follows the command one cycle later: aligned with the compare point.
    for (int i = 0; i < 4; i++) begin
      relayCmd = ~relayCmd;
      if (i % 2 == 0) switchCmd = ~switchCmd;
      tick(1);
      relayFb  = relayCmd;
      switchFb = ~switchCmd;
      for (int k = 0; k < 5 + XL; k++) begin
        tick(1);
        chk("follow_status", fbStatus, 2'b00);
      end
    end
    chk("follow_err", errCount, 2'd0);

    // Readback three cycles behind the command: a two-cycle settle, no error.
    relayCmd = 1'b1;
    tick(3);
    relayFb = 1'b1;
    tick(1 + XL);
    chk("lag3_settling", fbStatus, 2'b01);
    tick(3);
    chk("lag3_recovered", fbStatus, 2'b00);
    chk("lag3_err", errCount, 2'd0);

    // Relay readback low for SETTLE_MAX-1 compare cycles after relayCmd rises.
    relayCmd = 1'b0;
    tick(1);
    relayFb = 1'b0;
    tick(4 + XL);
    relayCmd = 1'b1;
    tick(SM);
    chk("short_settling", fbStatus, 2'b01);
    relayFb = 1'b1;
    tick(4 + XL);
    chk("short_recovered", fbStatus, 2'b00);
    chk("short_err", errCount, 2'd0);

    // Relay mismatch of SETTLE_MAX+4 cycles, restarted by a switch command toggle mid-way.
    relayFb = 1'b0;
    tick(5);
    switchCmd = ~switchCmd;
    tick(1);
    switchFb = ~switchCmd;
    tick(10);
    chk("restart_settling", fbStatus, 2'b01);
    relayFb = 1'b1;
    tick(4 + XL);
    chk("restart_status", fbStatus, 2'b00);
    chk("restart_err", errCount, 2'd0);

    // First settle failure: exactly SETTLE_MAX mismatching cycles.
    stuck_switch(SM);
    tick(2 + XL);
    chk("err1_error_state", fbStatus, 2'b01);
    chk("err1_before", errCount, 2'd0);
    tick(1);
    chk("err1_after", errCount, 2'd1);
    chk("err1_status", fbStatus, 2'b00);

    // monEn drops mid-settle: disabled next cycle, count kept, nothing counted while off.
    switchFb = switchCmd;
    tick(6 + XL);
    chk("monen_settling", fbStatus, 2'b01);
    monEn = 1'b0;
    tick(1);
    chk("monen_off_status", fbStatus, 2'b11);
    chk("monen_off_err", errCount, 2'd1);
    tick(SM + 4);
    chk("monen_hold_status", fbStatus, 2'b11);
    chk("monen_hold_err", errCount, 2'd1);
    switchFb = ~switchCmd;
    tick(3 + XL);
    monEn = 1'b1;
    tick(1);
    chk("monen_back_status", fbStatus, 2'b00);
    tick(2);
    chk("monen_back_steady", fbStatus, 2'b00);

    clrErr = 1'b1;
    tick(1);
    clrErr = 1'b0;
    chk("clr_track", errCount, 2'd0);

`ifdef FB_GLITCH_FILTER_EN
    // One-cycle relay readback glitches every three cycles are absorbed by the filter.
    for (int g = 0; g < 6; g++) begin
      relayFb = 1'b0;
      tick(1);
      relayFb = 1'b1;
      tick(2);
      chk("glitch_status", fbStatus, 2'b00);
    end
    tick(4 + XL);
    chk("glitch_err", errCount, 2'd0);
`endif

    stuck_switch(SM);
    tick(2 + XL);
    tick(1);
    chk("err_a", errCount, 2'd1);

    // clrErr coincides with the ERROR increment: the increment wins.
    stuck_switch(SM);
    tick(2 + XL);
    chk("coincide_error_state", fbStatus, 2'b01);
    chk("coincide_before", errCount, 2'd1);
    clrErr = 1'b1;
    tick(1);
    clrErr = 1'b0;
    chk("coincide_after", errCount, 2'd2);
    chk("coincide_status", fbStatus, 2'b00);

    // Third failure locks.
    stuck_switch(SM);
    tick(2 + XL);
    chk("lock_before_err", errCount, 2'd2);
    chk("lock_before_fault", {1'b0, fbFault}, 2'b00);
    tick(1);
    chk("lock_err", errCount, 2'd3);
    chk("lock_status", fbStatus, 2'b10);
    chk("lock_fault", {1'b0, fbFault}, 2'b01);

    monEn = 1'b0;
    tick(2);
    chk("lock_monen_status", fbStatus, 2'b10);
    clrErr = 1'b1;
    tick(1);
    clrErr = 1'b0;
    tick(1);
    chk("lock_clr_err", errCount, 2'd3);
    chk("lock_clr_fault", {1'b0, fbFault}, 2'b01);
    chk("lock_clr_status", fbStatus, 2'b10);

    rst = 1'b0;
    #1;
    chk("rst_exit_status", fbStatus, 2'b11);
    chk("rst_exit_fault", {1'b0, fbFault}, 2'b00);
    chk("rst_exit_err", errCount, 2'd0);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("rst_exit_disabled", fbStatus, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
